// File: rtl/uart_rx.sv
// uart_rx: UART receiver that finds the start edge, samples each bit at mid-bit,
// and checks optional parity and the stop bit. Optional feature macro: UART_RX_GLITCH_FILTER_EN.
module uart_rx #(
  parameter int CLK_PER_BIT = 868,
  parameter int PACK_SIZE   = 8,
  parameter int PARITY_EN   = 0,
  parameter int EVEN_PAR    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_bit,
  output logic                 rx_byte_valid,
  output logic [PACK_SIZE-1:0] rx_byte_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_active
);

  localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int IW = (PACK_SIZE > 1) ? $clog2(PACK_SIZE) : 1;
  localparam logic [CW-1:0] HALF     = CW'((CLK_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST     = CW'(CLK_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(PACK_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t state, state_next;

  logic                 sync1, rxs, smp;
  logic [CW-1:0]        clk_counter, counter_next;
  logic [IW-1:0]        data_index, index_next;
  logic [PACK_SIZE-1:0] shift, shift_next;
  logic                 perr, perr_next;
  logic                 exp_par;
  logic                 valid_next, active_next, pe_next, fe_next;
  logic [PACK_SIZE-1:0] data_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx_bit;
      rxs   <= sync1;
    end
  end

`ifdef UART_RX_GLITCH_FILTER_EN
  // Two previous samples plus the current one form the 3-sample voting window.
  logic [1:0] hist;
  logic [2:0] window;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hist <= 2'b11;
    else      hist <= {hist[0], rxs};
  end

  assign window = {hist, rxs};
  assign smp = (window[0] & window[1]) | (window[0] & window[2]) | (window[1] & window[2]);
`else
  assign smp = rxs;
`endif

  assign exp_par = (EVEN_PAR != 0) ? ^shift : ~^shift;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      clk_counter   <= '0;
      data_index    <= '0;
      shift         <= '0;
      perr          <= 1'b0;
      rx_byte_valid <= 1'b0;
      rx_byte_data  <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_active     <= 1'b0;
    end else begin
      state         <= state_next;
      clk_counter   <= counter_next;
      data_index    <= index_next;
      shift         <= shift_next;
      perr          <= perr_next;
      rx_byte_valid <= valid_next;
      rx_byte_data  <= data_next;
      rx_parity_err <= pe_next;
      rx_frame_err  <= fe_next;
      rx_active     <= active_next;
    end
  end

  // Errored packets still strobe; the flags travel with the data.
  always_comb begin
    state_next   = state;
    counter_next = clk_counter;
    index_next   = data_index;
    shift_next   = shift;
    perr_next    = perr;
    valid_next   = 1'b0;
    data_next    = rx_byte_data;
    pe_next      = rx_parity_err;
    fe_next      = rx_frame_err;
    active_next  = rx_active;

    case (state)
      IDLE: begin
        counter_next = '0;
        index_next   = '0;
        perr_next    = 1'b0;
        if (!smp) begin
          state_next  = START;
          active_next = 1'b1;
        end
      end

      START: begin
        if (clk_counter == HALF) begin
          counter_next = '0;
          if (!smp) begin
            state_next = DATA;
          end else begin
            state_next  = IDLE;
            active_next = 1'b0;
          end
        end else begin
          counter_next = clk_counter + 1'b1;
        end
      end

      DATA: begin
        if (clk_counter == LAST) begin
          counter_next           = '0;
          shift_next[data_index] = smp;
          if (data_index == LAST_IDX) begin
            index_next = '0;
            state_next = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            index_next = data_index + 1'b1;
          end
        end else begin
          counter_next = clk_counter + 1'b1;
        end
      end

      PARITY: begin
        if (clk_counter == LAST) begin
          counter_next = '0;
          perr_next    = (smp != exp_par);
          state_next   = STOP;
        end else begin
          counter_next = clk_counter + 1'b1;
        end
      end

      STOP: begin
        if (clk_counter == LAST) begin
          counter_next = '0;
          valid_next   = 1'b1;
          data_next    = shift;
          pe_next      = (PARITY_EN != 0) ? perr : 1'b0;
          fe_next      = ~smp;
          active_next  = 1'b0;
          state_next   = smp ? IDLE : WAIT_HIGH;
        end else begin
          counter_next = clk_counter + 1'b1;
        end
      end

      // A held-low line must return high before another start is accepted.
      WAIT_HIGH: begin
        counter_next = '0;
        if (smp) state_next = IDLE;
      end

      default: begin
        state_next   = IDLE;
        counter_next = '0;
        index_next   = '0;
        active_next  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 16 clocks per bit, with one
// parity-off instance and one even-parity instance on separate serial lines.
module tb_uart_rx;

  localparam int CPB = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rx_a, rx_b;
  logic       valid_a, valid_b;
  logic [7:0] data_a, data_b;
  logic       pe_a, pe_b, fe_a, fe_b, act_a, act_b;

  int   checks = 0;
  int   passed = 0;
  int   cycle  = 0;
  int   last_a = 0;
  int   prev_a = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  uart_rx #(.CLK_PER_BIT(CPB), .PACK_SIZE(8), .PARITY_EN(0), .EVEN_PAR(0)) u_plain (
    .clk(clk), .rst(rst), .rx_bit(rx_a),
    .rx_byte_valid(valid_a), .rx_byte_data(data_a),
    .rx_parity_err(pe_a), .rx_frame_err(fe_a), .rx_active(act_a)
  );

  uart_rx #(.CLK_PER_BIT(CPB), .PACK_SIZE(8), .PARITY_EN(1), .EVEN_PAR(1)) u_par (
    .clk(clk), .rst(rst), .rx_bit(rx_b),
    .rx_byte_valid(valid_b), .rx_byte_data(data_b),
    .rx_parity_err(pe_b), .rx_frame_err(fe_b), .rx_active(act_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard consumers: every strobe must match the oldest expected packet.
  always @(negedge clk) begin
    if (rst && valid_a) begin
      checks++;
      if (q_a.size() == 0) begin
        $display("[TB] FAIL unexpected_strobe_a: got data=%h pe=%b fe=%b, required no strobe", data_a, pe_a, fe_a);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        if ({data_a, pe_a, fe_a} !== e)
          $display("[TB] FAIL packet_a: got data=%h pe=%b fe=%b, required data=%h pe=%b fe=%b",
                   data_a, pe_a, fe_a, e.data, e.pe, e.fe);
        else
          passed++;
      end
      prev_a = last_a;
      last_a = cycle;
    end
  end

  always @(negedge clk) begin
    if (rst && valid_b) begin
      checks++;
      if (q_b.size() == 0) begin
        $display("[TB] FAIL unexpected_strobe_b: got data=%h pe=%b fe=%b, required no strobe", data_b, pe_b, fe_b);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        if ({data_b, pe_b, fe_b} !== e)
          $display("[TB] FAIL packet_b: got data=%h pe=%b fe=%b, required data=%h pe=%b fe=%b",
                   data_b, pe_b, fe_b, e.data, e.pe, e.fe);
        else
          passed++;
      end
    end
  end

  task automatic drive(input int line, input logic v);
    if (line == 0) rx_a = v;
    else           rx_b = v;
  endtask

  task automatic hold_bits(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input int line, input logic [7:0] d, input bit has_par,
                            input bit par_bit, input bit stop_val);
    drive(line, 1'b0);
    hold_bits(1);
    for (int i = 0; i < 8; i++) begin
      drive(line, d[i]);
      hold_bits(1);
    end
    if (has_par) begin
      drive(line, par_bit);
      hold_bits(1);
    end
    drive(line, stop_val);
    hold_bits(1);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 40 * CPB) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0)
      $display("[TB] FAIL %s_drain: got %0d/%0d packets outstanding, required 0", name, q_a.size(), q_b.size());
    else
      passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx_a = 1'b1;
    rx_b = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({valid_a, data_a, pe_a, fe_a, act_a} !== 12'h000)
      $display("[TB] FAIL reset_a: got %h, required 000", {valid_a, data_a, pe_a, fe_a, act_a});
    else passed++;
    checks++;
    if ({valid_b, data_b, pe_b, fe_b, act_b} !== 12'h000)
      $display("[TB] FAIL reset_b: got %h, required 000", {valid_b, data_b, pe_b, fe_b, act_b});
    else passed++;
    rst = 1'b1;
    hold_bits(2);
  endtask

  task automatic test_basic();
    q_a.push_back('{data: 8'hAA, pe: 1'b0, fe: 1'b0});
    drive(0, 1'b0);
    hold_bits(1);
    checks++;
    if (act_a !== 1'b1) $display("[TB] FAIL basic_active: got %b, required 1", act_a);
    else passed++;
    for (int i = 1; i < 8; i += 2) begin
      drive(0, 1'b0);
      hold_bits(1);
      drive(0, 1'b1);
      hold_bits(1);
    end
    drive(0, 1'b1);
    hold_bits(3);
    wait_drain("basic");
    checks++;
    if (data_a !== 8'hAA || act_a !== 1'b0)
      $display("[TB] FAIL basic_hold: got data=%h active=%b, required data=aa active=0", data_a, act_a);
    else passed++;
  endtask

  task automatic test_parity();
    q_b.push_back('{data: 8'h5A, pe: 1'b0, fe: 1'b0});
    send_frame(1, 8'h5A, 1'b1, 1'b0, 1'b1);
    hold_bits(1);
    q_b.push_back('{data: 8'h5A, pe: 1'b1, fe: 1'b0});
    send_frame(1, 8'h5A, 1'b1, 1'b1, 1'b1);
    hold_bits(2);
    wait_drain("parity");
    checks++;
    if (pe_b !== 1'b1) $display("[TB] FAIL parity_hold: got %b, required 1", pe_b);
    else passed++;
  endtask

  task automatic test_frame_err();
    q_a.push_back('{data: 8'h3C, pe: 1'b0, fe: 1'b1});
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    hold_bits(39);
    checks++;
    if (act_a !== 1'b0) $display("[TB] FAIL frame_stuck_low_active: got %b, required 0", act_a);
    else passed++;
    drive(0, 1'b1);
    hold_bits(2);
    wait_drain("frame_err");
    q_a.push_back('{data: 8'h55, pe: 1'b0, fe: 1'b0});
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
    hold_bits(2);
    wait_drain("frame_recover");
  endtask

  task automatic test_false_start();
    bit seen;
    seen = 1'b0;
    drive(0, 1'b0);
    repeat (4) @(negedge clk);
    drive(0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (act_a) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1) $display("[TB] FAIL false_start_rise: got active=%b, required 1", seen);
    else passed++;
    repeat (30) @(negedge clk);
    checks++;
    if (act_a !== 1'b0) $display("[TB] FAIL false_start_fall: got %b, required 0", act_a);
    else passed++;
`ifdef UART_RX_GLITCH_FILTER_EN
    seen = 1'b0;
    drive(0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (act_a) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) $display("[TB] FAIL glitch_reject: got active=%b, required 0", seen);
    else passed++;
`endif
    hold_bits(2);
  endtask

  task automatic test_back_to_back();
    q_a.push_back('{data: 8'h01, pe: 1'b0, fe: 1'b0});
    q_a.push_back('{data: 8'hFE, pe: 1'b0, fe: 1'b0});
    send_frame(0, 8'h01, 1'b0, 1'b0, 1'b1);
    send_frame(0, 8'hFE, 1'b0, 1'b0, 1'b1);
    hold_bits(2);
    wait_drain("back_to_back");
    checks++;
    if (last_a - prev_a != 10 * CPB)
      $display("[TB] FAIL b2b_spacing: got %0d cycles, required %0d", last_a - prev_a, 10 * CPB);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'h77;
    drive(0, 1'b0);
    hold_bits(1);
    for (int i = 0; i < 3; i++) begin
      drive(0, d[i]);
      hold_bits(1);
    end
    drive(0, d[3]);
    repeat (CPB / 2) @(negedge clk);
    checks++;
    if (act_a !== 1'b1) $display("[TB] FAIL mid_frame_active: got %b, required 1", act_a);
    else passed++;
    rst = 1'b0;
    #1;
    checks++;
    if ({valid_a, data_a, pe_a, fe_a, act_a} !== 12'h000)
      $display("[TB] FAIL reset_mid_clear: got %h, required 000", {valid_a, data_a, pe_a, fe_a, act_a});
    else passed++;
    drive(0, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    hold_bits(12);
    checks++;
    if (valid_a !== 1'b0 || act_a !== 1'b0)
      $display("[TB] FAIL reset_mid_quiet: got valid=%b active=%b, required 0 0", valid_a, act_a);
    else passed++;
    q_a.push_back('{data: 8'h12, pe: 1'b0, fe: 1'b0});
    send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1);
    hold_bits(2);
    wait_drain("reset_mid_next");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_false_start();
    test_back_to_back();
    test_reset_mid();
    hold_bits(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
